// File: rtl/ray_packet_assembler_if.sv
// Bus bundle between the ray FIFO read port, the assembler and the traversal stage.
// master = assembler side, slave = FIFO/traversal side.
interface ray_packet_assembler_if #(
    parameter int WORDS_PER_RAY = 9,
    parameter int DATA_WIDTH    = 32
);
    logic                                iFifoEmpty;
    logic                                oFifoPop;
    logic [DATA_WIDTH-1:0]               iFifoData;
    logic                                oRayValid;
    logic                                iRayReady;
    logic [WORDS_PER_RAY*DATA_WIDTH-1:0] oRayData;

    modport master (
        input  iFifoEmpty, iFifoData, iRayReady,
        output oFifoPop, oRayValid, oRayData
    );

    modport slave (
        output iFifoEmpty, iFifoData, iRayReady,
        input  oFifoPop, oRayValid, oRayData
    );
endinterface

// File: rtl/ray_packet_assembler.sv
// Pops ray-generator FIFO words and groups them into fixed-size ray packets,
// handing each complete packet to traversal over a valid/ready handshake.
module ray_packet_assembler #(
    parameter int WORDS_PER_RAY = 9,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iEnable,
    input  logic                  iFlush,
    ray_packet_assembler_if.master bus,
    output logic [15:0]           oRayCount,
    output logic                  oBusy
);
    localparam logic [3:0] FULL = 4'(WORDS_PER_RAY);
    localparam logic [3:0] LAST = 4'(WORDS_PER_RAY - 1);

    typedef enum logic {S_FILL, S_OUT} state_t;

    state_t                              rState, nextState;
    logic [3:0]                          rIssued, rCaptured;
    logic                                rPopPending;
    logic                                rRayValid;
    logic [WORDS_PER_RAY*DATA_WIDTH-1:0] rData;
    logic                                pop, flushFill, capture, complete, handshake;

    // A flush in S_FILL also swallows the word returning from the previous pop.
    assign flushFill = iFlush & (rState == S_FILL);
    assign capture   = rPopPending & ~flushFill;
    assign complete  = capture & (rCaptured == LAST);
    assign handshake = rRayValid & bus.iRayReady;

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) rState <= S_FILL;
        else        rState <= nextState;
    end

    always_comb begin
        nextState = rState;
        case (rState)
            S_FILL: if (complete)  nextState = S_OUT;
            S_OUT:  if (handshake) nextState = S_FILL;
            default: nextState = S_FILL;
        endcase
    end

    always_comb begin
        pop   = (rState == S_FILL) & iEnable & ~bus.iFifoEmpty & ~iFlush
              & (rIssued < FULL) & ~iReset;
        oBusy = (rIssued != 4'd0) | rPopPending | rRayValid;
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            rIssued     <= 4'd0;
            rCaptured   <= 4'd0;
            rPopPending <= 1'b0;
            rRayValid   <= 1'b0;
            oRayCount   <= 16'd0;
        end else begin
            rPopPending <= pop;
            if (handshake) begin
                rIssued   <= 4'd0;
                rCaptured <= 4'd0;
                rRayValid <= 1'b0;
                oRayCount <= oRayCount + 16'd1;
            end else if (flushFill) begin
                rIssued   <= 4'd0;
                rCaptured <= 4'd0;
            end else begin
                if (pop)      rIssued   <= rIssued + 4'd1;
                if (capture)  rCaptured <= rCaptured + 4'd1;
                if (complete) rRayValid <= 1'b1;
            end
        end
    end

    // Slots are only overwritten by captures; a flush leaves stale words in place.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            rData <= '0;
        end else begin
            for (int k = 0; k < WORDS_PER_RAY; k++) begin
                if (capture && (rCaptured == 4'(k)))
                    rData[k*DATA_WIDTH +: DATA_WIDTH] <= bus.iFifoData;
            end
        end
    end

    assign bus.oFifoPop  = pop;
    assign bus.oRayValid = rRayValid;
    assign bus.oRayData  = rData;
endmodule

// File: tb/tb_ray_packet_assembler.sv
// Directed bench for ray_packet_assembler with a small behavioural FIFO model.
module tb_ray_packet_assembler;
    localparam int W  = 9;
    localparam int DW = 32;

    logic        iClock = 1'b0;
    logic        iReset, iEnable, iFlush, rayReady, forceEmpty;
    logic [15:0] oRayCount;
    logic        oBusy;
    logic [31:0] mem [0:255];
    int          wrPtr = 0;
    int          rdPtr = 0;
    logic [31:0] fifoDataReg = '0;
    int          checks = 0;
    int          failures = 0;

    ray_packet_assembler_if #(.WORDS_PER_RAY(W), .DATA_WIDTH(DW)) bus ();

    ray_packet_assembler #(.WORDS_PER_RAY(W), .DATA_WIDTH(DW)) dut (
        .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iFlush(iFlush),
        .bus(bus), .oRayCount(oRayCount), .oBusy(oBusy)
    );

    always #5 iClock = ~iClock;

    // FIFO model: read data appears the cycle after the pop.
    assign bus.iFifoEmpty = (rdPtr == wrPtr) | forceEmpty;
    assign bus.iFifoData  = fifoDataReg;
    assign bus.iRayReady  = rayReady;

    always @(posedge iClock) begin
        if (bus.oFifoPop === 1'b1) begin
            fifoDataReg <= mem[rdPtr];
            rdPtr       <= rdPtr + 1;
        end
    end

    function automatic logic [31:0] wordOf(input int k);
        return bus.oRayData[k*DW +: DW];
    endfunction

    task automatic loadWords(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wrPtr] = base + 32'(i);
            wrPtr++;
        end
    endtask

    // Call at a negedge; returns at negedge+1 of the first cycle with oRayValid high.
    task automatic waitPacket(output int pops, output int firstPop, output int lastPop,
                              output int validAt, output bit seen);
        pops = 0; firstPop = -1; lastPop = -1; validAt = -1; seen = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            #1;
            if (bus.oFifoPop === 1'b1) begin
                if (pops == 0) firstPop = cyc;
                lastPop = cyc;
                pops++;
            end
            if (bus.oRayValid === 1'b1) begin
                validAt = cyc;
                seen = 1'b1;
                break;
            end
            @(negedge iClock);
        end
    endtask

    task automatic test_reset();
        iReset = 1'b1; iEnable = 1'b1; iFlush = 1'b0; rayReady = 1'b1; forceEmpty = 1'b0;
        loadWords(32'h100, 9);
        repeat (2) @(negedge iClock);
        #1;
        checks++; if (bus.oFifoPop !== 1'b0) begin failures++; $display("FAIL reset_pop got=%0h exp=0", bus.oFifoPop); end
        checks++; if (bus.oRayValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", bus.oRayValid); end
        checks++; if (bus.oRayData !== '0) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.oRayData); end
        checks++; if (oRayCount !== 16'd0 || oBusy !== 1'b0) begin failures++; $display("FAIL reset_count_busy got=%0h/%0h exp=0/0", oRayCount, oBusy); end
        @(negedge iClock);
        iReset = 1'b0;
    endtask

    task automatic test_single_packet();
        int pops, firstPop, lastPop, validAt; bit seen;
        waitPacket(pops, firstPop, lastPop, validAt, seen);
        checks++; if (!seen) begin failures++; $display("FAIL single_valid got=timeout exp=valid"); end
        checks++; if (pops != 9 || lastPop - firstPop != 8) begin failures++; $display("FAIL single_pops got=%0d span=%0d exp=9 span=8", pops, lastPop - firstPop); end
        checks++; if (validAt - lastPop != 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", validAt - lastPop); end
        checks++; if (wordOf(0) !== 32'h100 || wordOf(8) !== 32'h108) begin failures++; $display("FAIL single_data got=%0h/%0h exp=100/108", wordOf(0), wordOf(8)); end
        @(negedge iClock); #1;
        checks++; if (bus.oRayValid !== 1'b0 || oRayCount !== 16'd1) begin failures++; $display("FAIL single_handshake got=v%0h c%0d exp=v0 c1", bus.oRayValid, oRayCount); end
    endtask

    task automatic test_ready_stall();
        int pops, firstPop, lastPop, validAt; bit seen;
        logic [W*DW-1:0] snap;
        logic [15:0] base;
        @(negedge iClock);
        base = oRayCount;
        rayReady = 1'b0;
        loadWords(32'h100, 9);
        loadWords(32'h100, 9);
        waitPacket(pops, firstPop, lastPop, validAt, seen);
        snap = bus.oRayData;
        checks++; if (!seen || wordOf(0) !== 32'h100) begin failures++; $display("FAIL stall_first got=%0h exp=100", wordOf(0)); end
        for (int h = 1; h < 5; h++) begin
            @(negedge iClock); #1;
            checks++;
            if (bus.oRayValid !== 1'b1 || bus.oRayData !== snap || bus.oFifoPop !== 1'b0) begin
                failures++; $display("FAIL stall_hold cycle=%0d got=v%0h p%0h exp=v1 p0 data held", h, bus.oRayValid, bus.oFifoPop);
            end
        end
        @(negedge iClock);
        rayReady = 1'b1;
        #1;
        checks++; if (bus.oRayValid !== 1'b1) begin failures++; $display("FAIL stall_sixth got=%0h exp=1", bus.oRayValid); end
        @(negedge iClock); #1;
        checks++; if (bus.oRayValid !== 1'b0 || oRayCount !== base + 16'd1) begin failures++; $display("FAIL stall_handshake got=v%0h c%0d exp=v0 c%0d", bus.oRayValid, oRayCount, base + 16'd1); end
        @(negedge iClock);
        waitPacket(pops, firstPop, lastPop, validAt, seen);
        checks++; if (!seen || wordOf(0) !== 32'h100 || wordOf(8) !== 32'h108) begin failures++; $display("FAIL stall_second got=%0h/%0h exp=100/108", wordOf(0), wordOf(8)); end
        @(negedge iClock);
    endtask

    task automatic test_back_to_back();
        int pops, firstPop, lastPop, validAt; bit seen;
        logic [15:0] base;
        @(negedge iClock);
        base = oRayCount;
        loadWords(32'h100, 18);
        waitPacket(pops, firstPop, lastPop, validAt, seen);
        checks++; if (!seen || wordOf(0) !== 32'h100 || wordOf(8) !== 32'h108) begin failures++; $display("FAIL b2b_first got=%0h/%0h exp=100/108", wordOf(0), wordOf(8)); end
        @(negedge iClock); #1;
        checks++; if (bus.oFifoPop !== 1'b1 || bus.oRayValid !== 1'b0) begin failures++; $display("FAIL b2b_gap got=p%0h v%0h exp=p1 v0", bus.oFifoPop, bus.oRayValid); end
        @(negedge iClock);
        waitPacket(pops, firstPop, lastPop, validAt, seen);
        checks++; if (!seen || wordOf(0) !== 32'h109 || wordOf(8) !== 32'h111) begin failures++; $display("FAIL b2b_second got=%0h/%0h exp=109/111", wordOf(0), wordOf(8)); end
        @(negedge iClock); #1;
        checks++; if (oRayCount !== base + 16'd2) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", oRayCount, base + 16'd2); end
    endtask

    task automatic test_fifo_empty();
        int pops, firstPop, lastPop, validAt, cnt; bit seen;
        @(negedge iClock);
        loadWords(32'h100, 9);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.oFifoPop === 1'b1) cnt++;
            if (cnt == 4) break;
            @(negedge iClock);
        end
        @(negedge iClock);
        forceEmpty = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (bus.oFifoPop !== 1'b0 || oBusy !== 1'b1) begin
                failures++; $display("FAIL empty_wait cycle=%0d got=p%0h b%0h exp=p0 b1", c, bus.oFifoPop, oBusy);
            end
            @(negedge iClock);
        end
        forceEmpty = 1'b0;
        waitPacket(pops, firstPop, lastPop, validAt, seen);
        checks++; if (!seen || pops != 5) begin failures++; $display("FAIL empty_resume got=%0d exp=5", pops); end
        for (int k = 0; k < W; k++) begin
            checks++;
            if (wordOf(k) !== 32'h100 + 32'(k)) begin failures++; $display("FAIL empty_word%0d got=%0h exp=%0h", k, wordOf(k), 32'h100 + 32'(k)); end
        end
        @(negedge iClock);
    endtask

    task automatic test_flush();
        int pops, firstPop, lastPop, validAt, cnt; bit seen;
        @(negedge iClock);
        loadWords(32'h1A0, 3);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.oFifoPop === 1'b1) cnt++;
            if (cnt == 3) break;
            @(negedge iClock);
        end
        @(negedge iClock);
        iFlush = 1'b1;
        loadWords(32'h200, 9);
        #1;
        checks++; if (bus.oFifoPop !== 1'b0) begin failures++; $display("FAIL flush_nopop got=%0h exp=0", bus.oFifoPop); end
        @(negedge iClock);
        iFlush = 1'b0;
        waitPacket(pops, firstPop, lastPop, validAt, seen);
        checks++; if (!seen || pops != 9) begin failures++; $display("FAIL flush_pops got=%0d exp=9", pops); end
        for (int k = 0; k < W; k++) begin
            checks++;
            if (wordOf(k) !== 32'h200 + 32'(k)) begin failures++; $display("FAIL flush_word%0d got=%0h exp=%0h", k, wordOf(k), 32'h200 + 32'(k)); end
        end
        @(negedge iClock);
    endtask

    task automatic test_async_reset();
        int pops, firstPop, lastPop, validAt, cnt; bit seen;
        @(negedge iClock);
        loadWords(32'h400, 13);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.oFifoPop === 1'b1) cnt++;
            if (cnt == 5) break;
            @(negedge iClock);
        end
        #1 iReset = 1'b1;
        #1;
        checks++;
        if (bus.oFifoPop !== 1'b0 || bus.oRayValid !== 1'b0 || bus.oRayData !== '0 || oRayCount !== 16'd0 || oBusy !== 1'b0) begin
            failures++; $display("FAIL arst_clear got=p%0h v%0h c%0d b%0h exp=all 0", bus.oFifoPop, bus.oRayValid, oRayCount, oBusy);
        end
        #1 iReset = 1'b0;
        @(negedge iClock);
        waitPacket(pops, firstPop, lastPop, validAt, seen);
        checks++; if (!seen) begin failures++; $display("FAIL arst_valid got=timeout exp=valid"); end
        for (int k = 0; k < W; k++) begin
            checks++;
            if (wordOf(k) !== 32'h404 + 32'(k)) begin failures++; $display("FAIL arst_word%0d got=%0h exp=%0h", k, wordOf(k), 32'h404 + 32'(k)); end
        end
        @(negedge iClock); #1;
        checks++; if (oRayCount !== 16'd1) begin failures++; $display("FAIL arst_count got=%0d exp=1", oRayCount); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_ready_stall();
        test_back_to_back();
        test_fifo_empty();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
